// File: rtl/srff_bank.sv
// srff_bank: WIDTH independent set/reset flags with preset, collision policy
// and optional auto-clear; `SRFF_BANK_COLL_CNT_EN adds a collision counter.
module srff_bank #(
  parameter int WIDTH          = 8,
  parameter int COLLIDE_MODE   = 0,
  parameter int AUTOCLR_CYCLES = 0,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_b,
  output logic [WIDTH-1:0] collide
`ifdef SRFF_BANK_COLL_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] coll_cnt
`endif
);

  localparam bit AC_EN = (AUTOCLR_CYCLES > 0);
  localparam int TW =
    AC_EN ? $clog2(AUTOCLR_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(AC_EN ? AUTOCLR_CYCLES - 1 : 0);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] col_q, col_d;
  logic [WIDTH-1:0] set_ev;
  logic [TW-1:0]    tmr_q [WIDTH];
  logic [TW-1:0]    tmr_d [WIDTH];

  always_comb begin
    q_d    = q_q;
    col_d  = '0;
    set_ev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tmr_d[i] = '0;
      if (!P[i]) begin
        q_d[i]    = 1'b1;
        set_ev[i] = 1'b1;
      end else begin
        unique case ({S[i], R[i]})
          2'b01: q_d[i] = 1'b0;
          2'b10: begin
            q_d[i]    = 1'b1;
            set_ev[i] = 1'b1;
          end
          2'b11: begin
            col_d[i] = 1'b1;
            case (COLLIDE_MODE)
              1: begin
                q_d[i]    = 1'b1;
                set_ev[i] = 1'b1;
              end
              2: q_d[i] = 1'b0;
              3: begin
                q_d[i]    = ~q_q[i];
                set_ev[i] = ~q_q[i];
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      // High with no new set event: advance toward the timeout
      if (AC_EN && !set_ev[i] && q_q[i] && q_d[i]) begin
        if (tmr_q[i] == T_LAST)
          q_d[i] = 1'b0;
        else
          tmr_d[i] = tmr_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= '0;
      col_q <= '0;
      for (int i = 0; i < WIDTH; i++)
        tmr_q[i] <= '0;
    end else begin
      q_q   <= q_d;
      col_q <= col_d;
      for (int i = 0; i < WIDTH; i++)
        tmr_q[i] <= tmr_d[i];
    end
  end

  assign Q       = q_q;
  assign Q_b     = ~q_q;
  assign collide = col_q;

`ifdef SRFF_BANK_COLL_CNT_EN
  // Sum is wide enough to hold max count plus a full-bank increment
  localparam int SW = CNT_W + $clog2(WIDTH + 1);
  localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum;

  always_comb begin
    sum = SW'(cnt_q);
    for (int i = 0; i < WIDTH; i++)
      sum = sum + SW'(col_d[i]);
    if (cnt_clr)
      cnt_d = '0;
    else if (sum > CMAX)
      cnt_d = {CNT_W{1'b1}};
    else
      cnt_d = sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign coll_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_srff_bank.sv
// Directed bench for srff_bank: one instance per collision mode plus
// an auto-clear instance (AUTOCLR_CYCLES=4), all sharing inputs.
module tb_srff_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P = 8'h5A;
  logic [7:0] S = 8'hFF;
  logic [7:0] R = 8'h0F;
  logic       cnt_clr = 1'b1;

  logic [7:0] q_m   [4];
  logic [7:0] qb_m  [4];
  logic [7:0] col_m [4];
  logic [3:0] cnt_m [4];
  logic [7:0] q_a, qb_a, col_a;
  logic [3:0] cnt_a;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    srff_bank #(
      .WIDTH(8), .COLLIDE_MODE(m),
      .AUTOCLR_CYCLES(0), .CNT_W(4)
    ) u_dut (
      .clk(clk), .rst(rst),
      .P(P), .S(S), .R(R),
      .Q(q_m[m]), .Q_b(qb_m[m]),
      .collide(col_m[m])
`ifdef SRFF_BANK_COLL_CNT_EN
      , .cnt_clr(cnt_clr), .coll_cnt(cnt_m[m])
`endif
    );
`ifndef SRFF_BANK_COLL_CNT_EN
    assign cnt_m[m] = '0;
`endif
  end

  srff_bank #(
    .WIDTH(8), .COLLIDE_MODE(0),
    .AUTOCLR_CYCLES(4), .CNT_W(4)
  ) u_ac (
    .clk(clk), .rst(rst),
    .P(P), .S(S), .R(R),
    .Q(q_a), .Q_b(qb_a), .collide(col_a)
`ifdef SRFF_BANK_COLL_CNT_EN
    , .cnt_clr(cnt_clr), .coll_cnt(cnt_a)
`endif
  );
`ifndef SRFF_BANK_COLL_CNT_EN
  assign cnt_a = '0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if (q_m[m] !== 8'h00 || qb_m[m] !== 8'hFF ||
          col_m[m] !== 8'h00 || cnt_m[m] !== 4'h0) begin
        n_err++;
        $display("FAIL reset_m%0d: Q=%h Q_b=%h col=%h cnt=%h want 00 ff 00 0",
                 m, q_m[m], qb_m[m], col_m[m], cnt_m[m]);
      end
    end
    n_cmp++;
    if (q_a !== 8'h00 || qb_a !== 8'hFF || col_a !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ac: Q=%h Q_b=%h col=%h want 00 ff 00",
               q_a, qb_a, col_a);
    end
    rst = 1'b1;
    cnt_clr = 1'b0;
    P = 8'hFF; S = 8'h0F; R = 8'h00;
    #1;
    n_cmp++;
    if (q_m[0] !== 8'h00) begin
      n_err++;
      $display("FAIL release_noedge: Q=%h want 00", q_m[0]);
    end
    step();
    n_cmp++;
    if (q_m[0] !== 8'h0F) begin
      n_err++;
      $display("FAIL release_first_edge: Q=%h want 0f", q_m[0]);
    end
  endtask

  task automatic test_basic();
    S = 8'h00; R = 8'hFF;
    step();
    n_cmp++;
    if (q_m[0] !== 8'h00) begin
      n_err++;
      $display("FAIL basic_clear_all: Q=%h want 00", q_m[0]);
    end
    S = 8'h0F; R = 8'h00;
    step();
    n_cmp++;
    if (q_m[0] !== 8'h0F || qb_m[0] !== 8'hF0) begin
      n_err++;
      $display("FAIL basic_set: Q=%h Q_b=%h want 0f f0", q_m[0], qb_m[0]);
    end
    S = 8'h00; R = 8'h03;
    step();
    n_cmp++;
    if (q_m[0] !== 8'h0C) begin
      n_err++;
      $display("FAIL basic_reset: Q=%h want 0c", q_m[0]);
    end
    P = 8'hFE; R = 8'h01;
    step();
    n_cmp++;
    if (q_m[0] !== 8'h0D || col_m[0] !== 8'h00) begin
      n_err++;
      $display("FAIL preset_beats_reset: Q=%h col=%h want 0d 00",
               q_m[0], col_m[0]);
    end
    P = 8'hFE; S = 8'h01; R = 8'h01;
    step();
    n_cmp++;
    if (col_m[0] !== 8'h00 || q_m[0] !== 8'h0D) begin
      n_err++;
      $display("FAIL preset_masks_collide: col=%h Q=%h want 00 0d",
               col_m[0], q_m[0]);
    end
    P = 8'hFF; S = 8'h00; R = 8'h00;
  endtask

  task automatic test_collide();
    logic [2:0] exp [4];
    exp[0] = 3'b111;
    exp[1] = 3'b111;
    exp[2] = 3'b000;
    exp[3] = 3'b010;
    S = 8'h00; R = 8'hFF;
    step();
    S = 8'h01; R = 8'h00;
    step();
    S = 8'h01; R = 8'h01;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int m = 0; m < 4; m++) begin
        n_cmp++;
        if (q_m[m][0] !== exp[m][2-c] || col_m[m] !== 8'h01) begin
          n_err++;
          $display("FAIL collide_m%0d_c%0d: Q0=%b col=%h want %b 01",
                   m, c, q_m[m][0], col_m[m], exp[m][2-c]);
        end
      end
    end
    S = 8'h00; R = 8'hFF;
    step();
    n_cmp++;
    if (col_m[3] !== 8'h00 || q_m[3] !== 8'h00) begin
      n_err++;
      $display("FAIL collide_drop: col=%h Q=%h want 00 00",
               col_m[3], q_m[3]);
    end
    R = 8'h00;
  endtask

  task automatic test_autoclr();
    logic [6:0] exp;
    S = 8'h00; R = 8'hFF;
    step();
    R = 8'h00;
    S = 8'h01;
    for (int e = 0; e < 6; e++) begin
      step();
      S = 8'h00;
      n_cmp++;
      if (q_a[0] !== (e < 4)) begin
        n_err++;
        $display("FAIL autoclr_single_e%0d: Q0=%b want %b",
                 e, q_a[0], (e < 4));
      end
    end
    exp = 7'b0111111;
    S = 8'h01;
    for (int e = 0; e < 7; e++) begin
      step();
      S = (e == 1) ? 8'h01 : 8'h00;
      n_cmp++;
      if (q_a[0] !== exp[e]) begin
        n_err++;
        $display("FAIL autoclr_rearm_e%0d: Q0=%b want %b",
                 e, q_a[0], exp[e]);
      end
    end
    S = 8'h01;
    step();
    S = 8'h00; R = 8'h01;
    step();
    R = 8'h00;
    n_cmp++;
    if (q_a[0] !== 1'b0) begin
      n_err++;
      $display("FAIL autoclr_explicit_clr: Q0=%b want 0", q_a[0]);
    end
    S = 8'h02; R = 8'h02;
    for (int e = 0; e < 4; e++) step();
    n_cmp++;
    if (q_a[1] !== 1'b0) begin
      n_err++;
      $display("FAIL autoclr_unexpected_set: Q1=%b want 0", q_a[1]);
    end
    S = 8'h00; R = 8'h00;
  endtask

  task automatic test_counter();
`ifdef SRFF_BANK_COLL_CNT_EN
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_cmp++;
    if (cnt_m[0] !== 4'd0) begin
      n_err++;
      $display("FAIL cnt_clear: cnt=%0d want 0", cnt_m[0]);
    end
    S = 8'hFF; R = 8'hFF;
    step();
    n_cmp++;
    if (cnt_m[0] !== 4'd8) begin
      n_err++;
      $display("FAIL cnt_first: cnt=%0d want 8", cnt_m[0]);
    end
    step();
    n_cmp++;
    if (cnt_m[0] !== 4'd15) begin
      n_err++;
      $display("FAIL cnt_saturate: cnt=%0d want 15", cnt_m[0]);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_cmp++;
    if (cnt_m[0] !== 4'd0) begin
      n_err++;
      $display("FAIL cnt_clr_wins: cnt=%0d want 0", cnt_m[0]);
    end
    P = 8'hF0;
    step();
    n_cmp++;
    if (cnt_m[0] !== 4'd4) begin
      n_err++;
      $display("FAIL cnt_preset_masked: cnt=%0d want 4", cnt_m[0]);
    end
    P = 8'hFF; S = 8'h00; R = 8'hFF;
    step();
    R = 8'h00;
`endif
  endtask

  task automatic test_async_reset();
    S = 8'hFF;
    step();
    S = 8'h00;
    step();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (q_a !== 8'h00 || qb_a !== 8'hFF || q_m[0] !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: Qac=%h Qb=%h Qm0=%h want 00 ff 00",
               q_a, qb_a, q_m[0]);
    end
    step();
    rst = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step();
      n_cmp++;
      if (q_a !== 8'h00 || q_m[1] !== 8'h00) begin
        n_err++;
        $display("FAIL post_reset_e%0d: Qac=%h Qm1=%h want 00 00",
                 e, q_a, q_m[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collide();
    test_autoclr();
    test_counter();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/srff_bank.md
# srff_bank

Parametrised bank of `WIDTH` independent set/reset flip-flops.
- Each channel has an active-low synchronous preset, a selectable resolution for simultaneous S and R, and an optional auto-clear timeout that turns a set into a fixed-length pulse.
- Used wherever the design latches sticky status or event flags: interrupt pending bits, error flags, handshake "seen" bits.
- Exports per-channel collision flags so control logic can detect conflicting set/clear requests.

## Interface
Parameters:
- `WIDTH`, 8: number of channels (≥1).
- `COLLIDE_MODE`, 0: action when S=R=1. 0 hold, 1 set, 2 clear, 3 toggle.
- `AUTOCLR_CYCLES`, 0: high-time limit in cycles. 0 disables auto-clear; otherwise ≥1.
- `CNT_W`, 8: collision counter width. Used only with the configuration macro.

Ports:
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `P`, input, `WIDTH`: per-channel preset, active-low, synchronous.
- `S`, input, `WIDTH`: per-channel set.
- `R`, input, `WIDTH`: per-channel reset.
- `Q`, output, `WIDTH`: flag state, registered.
- `Q_b`, output, `WIDTH`: `~Q`, combinational.
- `collide`, output, `WIDTH`: registered one-cycle flag marking that S=R=1 was sampled while P=1.
- `cnt_clr`, input, 1: synchronous clear of `coll_cnt`. Present only with the macro.
- `coll_cnt`, output, `CNT_W`: saturating collision count. Present only with the macro.

## Operation
Reset:
- `rst` low immediately forces `Q`=0, `collide`=0, all timers=0 and `coll_cnt`=0, independent of `clk`.
- `Q_b` therefore reads all ones during reset.

Per channel, priority at each edge:
1. P=0 → Q←1. This is a set event. `collide`←0 regardless of S and R.
2. Otherwise, by {S,R}:
   - 00: hold.
   - 01: Q←0.
   - 10: Q←1. Set event.
   - 11: resolved by `COLLIDE_MODE`; `collide`←1.
     - Mode 0: hold.
     - Mode 1: Q←1. Set event.
     - Mode 2: Q←0.
     - Mode 3: Q←~Q. A 0→1 toggle is a set event.
3. `collide`←0 for any case other than S=R=1 with P=1.

Auto-clear (only when `AUTOCLR_CYCLES`>0):
- Each channel has a timer `$clog2(AUTOCLR_CYCLES+1)` bits wide.
- Set event: Q←1, timer←0. This re-arms the timeout if Q is already 1.
- Q=1, no event, timer=`AUTOCLR_CYCLES`−1: Q←0, timer←0.
- Q=1, no event otherwise: timer←timer+1.
- Any clear (R, mode-2 collision, toggle to 0): timer←0.
- Q=0: timer holds 0.
- Result: after the last set event, Q is high for exactly `AUTOCLR_CYCLES` cycles.
- An explicit clear takes effect on its edge and overrides a pending timeout.
- Mode-0 collision holds and counts as "no event", so the timer keeps advancing.

Channels are fully independent. Any mix of events in one cycle is legal.

## Timing
- Latency: input sampled at edge k is reflected on `Q` and `collide` after edge k.
- `Q_b` follows `Q` combinationally with zero latency.
- Reset assertion is asynchronous. Deassertion must meet recovery timing to `clk`; the first functional edge is the first rising edge with `rst`=1.
- Reset mid-pulse discards the timer state. After deassertion Q stays 0 until a new set event.
- `AUTOCLR_CYCLES`=1: Q high exactly one cycle per set event. Continuous S keeps Q high.
- No handshake. Inputs are level-sampled every cycle.

## Configuration
Macro `SRFF_BANK_COLL_CNT_EN`.

When defined:
- Ports `cnt_clr` and `coll_cnt` exist.
- Each edge, `coll_cnt` ← min(`coll_cnt` + popcount(channels with S=R=1 and P=1), 2^`CNT_W`−1).
- `cnt_clr`=1 at an edge loads 0. Increments sampled on that edge are dropped.
- Saturation holds until `cnt_clr` or reset.

When undefined:
- The ports and counter logic are absent.
- All other behaviour is identical.

## Test plan
1. Reset with mixed inputs active, then release.
   - Required: Q=0, Q_b=all ones, collide=0, coll_cnt=0.
   - Required: Q responds only from the first edge after release.
2. WIDTH=8, mode 0: S=0x0F, R=0x00 for one cycle, then R=0x03.
   - Required: Q=0x0F, then Q=0x0C.
   - Then P=0xFE with R=0x01: Q[0]=1, since preset beats reset.
3. Collision, one run per mode 0–3, start Q[0]=1, hold S[0]=R[0]=1 for 3 cycles.
   - Required Q[0] per mode: 1,1,1 / 1,1,1 / 0,0,0 / 0,1,0.
   - Required: collide[0]=1 on each of the 3 cycles.
4. AUTOCLR_CYCLES=4: S pulse at edge 0.
   - Required: Q high during edges 0–3 output, low after edge 4.
   - Re-pulse S at edge 2: Q stays high through edge 5, low after edge 6.
   - R at edge 1 instead: Q low after edge 1.
5. Macro on, CNT_W=4, WIDTH=8: S=R=0xFF for 2 cycles.
   - Required: coll_cnt=8, then 15 (saturated).
   - cnt_clr concurrent with collisions: coll_cnt=0.
6. Assert `rst` between clock edges while Q=0xFF with auto-clear pending.
   - Required: Q=0 immediately, without waiting for an edge.
   - Required: no spurious clear or set after release.
